// File: rtl/fifo_in_overlap_wr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fifo_in_overlap_wr_ctrl
// Brief    : Write-side controller for FIFO_In_Overlap. It streams range bins
//            and replays the tail of each bin from a ring buffer.
//            Optional macro OVL_WR_PARAM_CHECK_EN enables rejection of
//            illegal parameters on trig.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_in_overlap_wr_ctrl #(
    parameter int DATA_W    = 16,
    parameter int NFFT      = 1024,
    parameter int OVL_DEPTH = 512
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trig,
    input  logic [15:0]       RANGEBIN_LENGTH,
    input  logic [15:0]       OVERLAP_LENGTH,
    input  logic [15:0]       RANGEBIN_COUNT,
    input  logic              src_empty,
    input  logic [DATA_W-1:0] src_dout,
    output logic              src_rd_en,
    input  logic              ovl_full,
    output logic              ovl_wr_en,
    output logic [DATA_W-1:0] ovl_din,
    output logic              start,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int AW = $clog2(OVL_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FILL   = 3'd1,
        S_REPLAY = 3'd2,
        S_NEW    = 3'd3,
        S_DRAIN  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [15:0]       ovl_q, ovl_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [15:0]       bin_q, bin_d;
    logic [15:0]       pt_q, pt_d;
    logic [AW-1:0]     wp_q;
    logic              wr_en_q;
    logic              sel_q;
    logic              fill_done_q;
    logic              start_q;
    logic              done_q;
    logic [DATA_W-1:0] ring_q;
    logic [DATA_W-1:0] ring_mem [OVL_DEPTH];

    logic              w_issue;
    logic              w_sel_ring;
    logic              w_fill_last;
    logic [15:0]       w_target;
    logic              w_src_ok;
    logic              w_param_ok;
    logic [15:0]       w_len_in;
    logic [AW-1:0]     w_raddr;
    logic [DATA_W-1:0] w_wdata;

`ifdef OVL_WR_PARAM_CHECK_EN
    logic err_q;

    assign w_param_ok = !((RANGEBIN_LENGTH == 16'd0) ||
                          (int'(RANGEBIN_LENGTH) > NFFT) ||
                          (OVERLAP_LENGTH >= RANGEBIN_LENGTH) ||
                          (int'(OVERLAP_LENGTH) >= OVL_DEPTH));
    assign w_len_in   = RANGEBIN_LENGTH;
    assign err        = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (state_q == S_IDLE && trig) begin
            err_q <= !w_param_ok;
        end
    end
`else
    assign w_param_ok = 1'b1;
    // Illegal lengths are undefined here; clamping keeps the bin bounded.
    assign w_len_in   = (int'(RANGEBIN_LENGTH) > NFFT) ? 16'(NFFT) : RANGEBIN_LENGTH;
    assign err        = 1'b0;
`endif

    assign w_src_ok  = !src_empty && !ovl_full;
    assign src_rd_en = w_issue && !w_sel_ring;

    // Issue pointer equals wp_q plus the word still in flight, so the replay
    // window is always the last ovl_q words issued.
    assign w_raddr   = wp_q + AW'(wr_en_q) - ovl_q[AW-1:0];
    assign w_wdata   = sel_q ? ring_q : src_dout;

    assign ovl_wr_en = wr_en_q;
    assign ovl_din   = wr_en_q ? w_wdata : '0;
    assign busy      = (state_q != S_IDLE);
    assign start     = start_q;
    assign done      = done_q;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        ovl_d       = ovl_q;
        cnt_d       = cnt_q;
        bin_d       = bin_q;
        pt_d        = pt_q;
        w_issue     = 1'b0;
        w_sel_ring  = 1'b0;
        w_fill_last = 1'b0;
        w_target    = 16'd0;

        case (state_q)
            S_IDLE: begin
                if (trig && w_param_ok) begin
                    len_d   = w_len_in;
                    ovl_d   = OVERLAP_LENGTH;
                    cnt_d   = RANGEBIN_COUNT;
                    bin_d   = 16'd0;
                    pt_d    = 16'd0;
                    state_d = (RANGEBIN_COUNT == 16'd0) ? S_DRAIN : S_FILL;
                end
            end
            S_FILL: begin
                w_issue  = w_src_ok;
                w_target = len_q;
            end
            S_REPLAY: begin
                w_issue    = !ovl_full;
                w_sel_ring = 1'b1;
                w_target   = ovl_q;
            end
            S_NEW: begin
                w_issue  = w_src_ok;
                w_target = len_q - ovl_q;
            end
            S_DRAIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (w_issue) begin
            if (pt_q == w_target - 16'd1) begin
                pt_d = 16'd0;
                case (state_q)
                    S_FILL: begin
                        w_fill_last = 1'b1;
                        bin_d       = 16'd1;
                        if (cnt_q == 16'd1) begin
                            state_d = S_DRAIN;
                        end else begin
                            state_d = (ovl_q == 16'd0) ? S_NEW : S_REPLAY;
                        end
                    end
                    S_REPLAY: begin
                        state_d = S_NEW;
                    end
                    default: begin
                        bin_d = bin_q + 16'd1;
                        if (bin_q + 16'd1 == cnt_q) begin
                            state_d = S_DRAIN;
                        end else begin
                            state_d = (ovl_q == 16'd0) ? S_NEW : S_REPLAY;
                        end
                    end
                endcase
            end else begin
                pt_d = pt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            len_q       <= 16'd0;
            ovl_q       <= 16'd0;
            cnt_q       <= 16'd0;
            bin_q       <= 16'd0;
            pt_q        <= 16'd0;
            wp_q        <= '0;
            wr_en_q     <= 1'b0;
            sel_q       <= 1'b0;
            fill_done_q <= 1'b0;
            start_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            ovl_q       <= ovl_d;
            cnt_q       <= cnt_d;
            bin_q       <= bin_d;
            pt_q        <= pt_d;
            wr_en_q     <= w_issue;
            sel_q       <= w_sel_ring;
            fill_done_q <= w_fill_last;
            start_q     <= fill_done_q;
            done_q      <= (state_q == S_DRAIN);
            if (wr_en_q) begin
                wp_q <= wp_q + AW'(1);
            end
        end
    end

    // Bypass covers a one-word overlap, where the replayed word is the one
    // being written in the same cycle.
    always_ff @(posedge clk) begin
        if (wr_en_q) begin
            ring_mem[wp_q] <= w_wdata;
        end
        ring_q <= (wr_en_q && (w_raddr == wp_q)) ? w_wdata : ring_mem[w_raddr];
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_in_overlap_wr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_in_overlap_wr_ctrl
// Brief    : Scoreboard bench for fifo_in_overlap_wr_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_in_overlap_wr_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        trig = 1'b0;
    logic [15:0] rb_len = '0, ov_len = '0, rb_cnt = '0;
    logic        src_empty = 1'b0;
    logic [15:0] src_dout = '0;
    logic        src_rd_en;
    logic        ovl_full = 1'b0;
    logic        ovl_wr_en;
    logic [15:0] ovl_din;
    logic        start, busy, done, err;

    fifo_in_overlap_wr_ctrl dut (
        .clk(clk), .rst(rst), .trig(trig),
        .RANGEBIN_LENGTH(rb_len), .OVERLAP_LENGTH(ov_len), .RANGEBIN_COUNT(rb_cnt),
        .src_empty(src_empty), .src_dout(src_dout), .src_rd_en(src_rd_en),
        .ovl_full(ovl_full), .ovl_wr_en(ovl_wr_en), .ovl_din(ovl_din),
        .start(start), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int seq = 0, rd_cnt = 0;
    int nwr, first_wr, last_wr, start_at, start_wr;
    int start_cnt, start_cyc, done_cnt, done_cyc;
    logic busy_at_done;
    logic full_last = 1'b0;
    logic [15:0] exp_q[$];
    logic tog_on = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Upstream FIFO model: data appears one cycle after the read strobe.
    initial begin
        logic r;
        forever begin
            @(negedge clk);
            r = src_rd_en;
            @(posedge clk);
            #1;
            if (r) begin
                src_dout = 16'(seq);
                seq++;
                rd_cnt++;
            end
        end
    end

    // Scoreboard monitor
    initial begin
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (src_rd_en) chk("rd_while_empty", int'(src_empty), 0);
            if (ovl_wr_en) begin
                chk("wr_after_full", int'(full_last), 0);
                chk("sb_nonempty", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("data", int'(ovl_din), int'(e));
                end
                nwr++;
                if (nwr == 1) first_wr = cyc;
                last_wr = cyc;
                if (nwr == start_at) start_wr = cyc;
            end
            if (start) begin
                start_cnt++;
                start_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                busy_at_done = busy;
            end
            full_last = ovl_full;
        end
    end

    task automatic start_run(input int l, input int o, input int c, input bit nostall);
        @(posedge clk);
        #1;
        nwr = 0; first_wr = -1; last_wr = -1; start_wr = -1; start_at = l;
        start_cnt = 0; start_cyc = -1; done_cnt = 0; done_cyc = -1;
        seq = 0; rd_cnt = 0;
        for (int b = 0; b < c; b++)
            for (int k = 0; k < l; k++)
                exp_q.push_back(16'(b * (l - o) + k));
        rb_len = 16'(l); ov_len = 16'(o); rb_cnt = 16'(c);
        trig = 1'b1;
        @(posedge clk);
        #1;
        trig = 1'b0;
        @(negedge clk);
        chk("busy_after_trig", int'(busy), 1);
        chk("err_after_trig", int'(err), 0);
        if (nostall) chk("first_rd_t1", int'(src_rd_en), 1);
    endtask

    task automatic finish_run(input int l, input int o, input int c, input bit nostall);
        int w;
        w = 0;
        while (done_cnt == 0 && w < 3000) begin
            @(posedge clk);
            w++;
        end
        repeat (3) @(posedge clk);
        chk("done_count", done_cnt, 1);
        chk("write_count", nwr, c * l);
        chk("sb_left", exp_q.size(), 0);
        chk("src_reads", rd_cnt, l + (c - 1) * (l - o));
        chk("start_count", start_cnt, 1);
        chk("start_timing", start_cyc, start_wr + 1);
        chk("done_timing", done_cyc, last_wr + 1);
        chk("busy_at_done", int'(busy_at_done), 0);
        if (nostall) chk("no_gaps", last_wr - first_wr, nwr - 1);
        exp_q.delete();
    endtask

    task automatic run(input int l, input int o, input int c);
        start_run(l, o, c, 1'b1);
        finish_run(l, o, c, 1'b1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_src_rd_en", int'(src_rd_en), 0);
        chk("rst_ovl_wr_en", int'(ovl_wr_en), 0);
        chk("rst_ovl_din", int'(ovl_din), 0);
        chk("rst_start", int'(start), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        run(8, 4, 3);
        run(8, 0, 3);
        run(8, 6, 3);
        run(8, 1, 2);
        run(4, 3, 3);

        // Stalls: src_empty toggles every cycle, ovl_full held during 2nd replay
        tog_on = 1'b1;
        fork
            begin
                start_run(8, 4, 3, 1'b0);
                finish_run(8, 4, 3, 1'b0);
                tog_on = 1'b0;
            end
            begin
                int w;
                w = 0;
                while (rd_cnt < 12 && w < 3000) begin
                    @(posedge clk);
                    w++;
                end
                @(posedge clk);
                #1;
                ovl_full = 1'b1;
                repeat (10) @(posedge clk);
                #1;
                ovl_full = 1'b0;
            end
            begin
                while (tog_on) begin
                    @(posedge clk);
                    #1;
                    src_empty = tog_on ? ~src_empty : 1'b0;
                end
                src_empty = 1'b0;
            end
        join

`ifdef OVL_WR_PARAM_CHECK_EN
        @(posedge clk);
        #1;
        rd_cnt = 0;
        rb_len = 16'd8; ov_len = 16'd8; rb_cnt = 16'd3;
        trig = 1'b1;
        @(posedge clk);
        #1;
        trig = 1'b0;
        @(negedge clk);
        chk("illegal_err", int'(err), 1);
        chk("illegal_busy", int'(busy), 0);
        repeat (6) @(posedge clk);
        chk("illegal_no_reads", rd_cnt, 0);
        run(8, 4, 3);
`endif

        // Reset in the middle of a NEW phase
        start_run(8, 4, 3, 1'b1);
        for (int i = 0; i < 200; i++) begin
            if (rd_cnt >= 10) break;
            @(posedge clk);
        end
        chk("reached_new", int'(rd_cnt >= 10), 1);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mrst_src_rd_en", int'(src_rd_en), 0);
        chk("mrst_ovl_wr_en", int'(ovl_wr_en), 0);
        chk("mrst_ovl_din", int'(ovl_din), 0);
        chk("mrst_start", int'(start), 0);
        chk("mrst_busy", int'(busy), 0);
        chk("mrst_done", int'(done), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        repeat (4) @(posedge clk);
        chk("mrst_no_done", done_cnt, 0);
        chk("mrst_start_once", start_cnt, 1);
        run(8, 4, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_in_overlap_wr_ctrl.md
# fifo_in_overlap_wr_ctrl

Write-side controller for FIFO_In_Overlap. It reads raw samples from the upstream sample FIFO and writes them into FIFO_In_Overlap as consecutive range bins, replaying the last OVERLAP_LENGTH samples of each bin at the head of the next bin. It keeps those samples in an internal ring buffer. It pulses `start` to the FIFO_In_Overlap read FSM once the first full bin is stored, so the reader never underruns mid-bin.

## Interface
Parameters:
- DATA_W, 16, sample width
- NFFT, 1024, maximum legal RANGEBIN_LENGTH
- OVL_DEPTH, 512, ring-buffer depth (power of two); legal OVERLAP_LENGTH ≤ OVL_DEPTH-1

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- trig  in  1  frame start pulse, honoured only in IDLE
- RANGEBIN_LENGTH  in  16  samples per bin, latched on trig
- OVERLAP_LENGTH  in  16  samples shared by adjacent bins, latched on trig
- RANGEBIN_COUNT  in  16  bins per frame, latched on trig
- src_empty  in  1  upstream FIFO empty
- src_dout  in  DATA_W  upstream FIFO data, valid 1 cycle after src_rd_en
- src_rd_en  out  1  upstream read strobe
- ovl_full  in  1  FIFO_In_Overlap programmable-full, asserted with ≥2 free entries
- ovl_wr_en  out  1  FIFO_In_Overlap write strobe
- ovl_din  out  DATA_W  FIFO_In_Overlap write data
- start  out  1  1-cycle pulse after the last write of bin 0
- busy  out  1  high from trig acceptance until done
- done  out  1  1-cycle pulse after the last write of the frame
- err  out  1  sticky illegal-parameter flag, cleared by the next accepted trig or by rst

## Operation
- States: IDLE, FILL, REPLAY, NEW, DRAIN.
- IDLE: on trig, latch parameters, clear bin_cnt and pt_cnt, then go to FILL. If RANGEBIN_COUNT=0, go directly to DRAIN.
- FILL (bin 0): issue src_rd_en whenever !src_empty && !ovl_full. Count RANGEBIN_LENGTH reads, then go to REPLAY, or to DRAIN if it was the last bin.
- REPLAY: issue ring reads whenever !ovl_full, starting at address ring_wp − OVERLAP_LENGTH (mod OVL_DEPTH), for OVERLAP_LENGTH reads. Then go to NEW. If OVERLAP_LENGTH=0, skip REPLAY and enter NEW directly.
- NEW: issue src_rd_en as in FILL for RANGEBIN_LENGTH − OVERLAP_LENGTH reads. At the end, increment bin_cnt, then go to REPLAY, or to DRAIN if bin_cnt = RANGEBIN_COUNT.
- DRAIN: wait 1 cycle for the last data to be written, pulse done, return to IDLE.
- Ring buffer: every word written to FIFO_In_Overlap, whether new or replayed, is also written to ring[ring_wp], and ring_wp increments. The RAM is read-before-write.
  - This makes overlap > half-bin work: replayed words become part of the next tail.
- Data path:
  - A 1-cycle issue pipeline `sel_d` records whether the issued read was from source or ring.
  - ovl_din = sel_d ? ring_q : src_dout.
  - ovl_wr_en is the issue strobe delayed by 1 cycle.
- Counters are 16-bit. The pt_cnt comparison uses the full width; no wrap occurs for legal parameters.
- trig while busy is ignored.

## Timing
- Reset values: src_rd_en=0, ovl_wr_en=0, ovl_din=0, start=0, busy=0, done=0, err=0. State is IDLE and ring_wp=0. Ring contents are not cleared.
- trig at cycle T:
  - busy=1 at T+1.
  - The first src_rd_en is possible at T+1.
  - Each ovl_wr_en lags its issue strobe by exactly 1 cycle.
- start is high the cycle after the RANGEBIN_LENGTH-th write of bin 0.
- done is high the cycle after the final write. busy falls in the same cycle.
- Back-pressure:
  - An issue in cycle n is gated by src_empty/ovl_full sampled in cycle n. No issue is made while gated.
  - The word already in the pipeline is still written, which is why ovl_full needs 2 entries of margin.
- Stalls never duplicate or drop samples.
- rst mid-frame: return to IDLE next cycle, outputs at reset values. The in-flight write is discarded. No done or start is produced.
- Throughput: 1 word per cycle when unstalled, including across FILL→REPLAY→NEW boundaries with no bubble.

## Configuration
- OVL_WR_PARAM_CHECK_EN defined:
  - On trig, reject RANGEBIN_LENGTH=0, RANGEBIN_LENGTH>NFFT, OVERLAP_LENGTH ≥ RANGEBIN_LENGTH, or OVERLAP_LENGTH ≥ OVL_DEPTH.
  - On rejection: set err=1, stay in IDLE, busy stays 0, no reads.
- Not defined:
  - No check; err is tied to 0.
  - Behaviour with illegal parameters is unspecified.

## Test plan
- LEN=8, OVL=4, COUNT=3, source 0,1,2,… never empty, FIFO never full → writes 0–7, 4–11, 8–15 (24 writes, 16 source reads); start after write 8; done after write 24; no gaps.
- OVL=0, LEN=8, COUNT=3 → 24 sequential writes 0–23; REPLAY never entered.
- LEN=8, OVL=6, COUNT=3 → writes 0–7, 2–9, 4–11.
- Case 1 with src_empty toggling every cycle, plus ovl_full held for 10 cycles during the second REPLAY → identical data sequence; no write within 1 cycle after a gated issue window.
- With OVL_WR_PARAM_CHECK_EN: LEN=8, OVL=8 → err=1, no src_rd_en, busy=0; the next legal trig clears err and runs normally.
- rst asserted mid-NEW → all outputs 0 next cycle; a following legal trig produces the correct full sequence.
